// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module sync_fifo_flags #(
  parameter int DEPTH    = 8,
  parameter int DWIDTH   = 16,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DWIDTH-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DWIDTH-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_CNT = PW'(AE_LEVEL);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] w_ptr_q, w_ptr_d;
  logic [PW-1:0] r_ptr_q, r_ptr_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic [AW-1:0] w_addr, r_addr;
  logic [PW-1:0] count_c;
  logic          full_c, empty_c;
  logic          wr_acc, rd_acc;

  assign w_addr  = w_ptr_q[AW-1:0];
  assign r_addr  = r_ptr_q[AW-1:0];
  assign empty_c = (w_ptr_q == r_ptr_q);
  assign full_c  = (w_addr == r_addr) && (w_ptr_q[AW] != r_ptr_q[AW]);
  assign count_c = w_ptr_q - r_ptr_q;

  // Acceptance is decided on the pre-edge state, so a full FIFO refuses a write even while popping.
  assign wr_acc = wr_en && !full_c;
  assign rd_acc = rd_en && !empty_c;

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    overflow_d  = overflow_q | (wr_en & full_c);
    underflow_d = underflow_q | (rd_en & empty_c);
    if (wr_acc) w_ptr_d = w_ptr_q + PW'(1);
    if (rd_acc) r_ptr_d = r_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[w_addr] <= wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data  = empty_c ? '0 : mem_q[r_addr];
  assign rd_valid = !empty_c;
`else
  logic [DWIDTH-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    if (rd_acc) rd_data_d = mem_q[r_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign full         = full_c;
  assign empty        = empty_c;
  assign count        = count_c;
  assign almost_full  = (count_c >= AF_CNT);
  assign almost_empty = (count_c <= AE_CNT);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
